uart_tx_frame: RTL and testbench

- Parametrised UART transmit frame engine that merges parity generation with framing and serialisation.
- Generalises the fixed 8-bit even/odd parity calculator. Adds:
  - runtime data length,
  - five parity modes (none/even/odd/mark/space),
  - 1 or 2 stop bits,
  - a frame-done strobe.
- Sits between the TX host interface and the line driver. CLK is the bit-rate clock: one line bit per CLK cycle.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_parity_gen.sv | 42 ++++
 rtl/uart_tx_frame.sv | 148 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared encodings and constants for the UART transmit frame engine
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    localparam int MIN_LEN = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_parity_gen.sv
// ============================================================================
// uart_parity_gen : registered parity unit, loads a new parity bit on strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] masked_data,
    input  logic [1:0]            mode,
    input  logic                  load,
    output logic                  Par_Bit
);

    logic par_next;

    always_comb begin
        par_next = 1'b0;
        case (mode)
            PAR_EVEN: par_next = ^masked_data;
            PAR_ODD:  par_next = ~(^masked_data);
            PAR_MARK: par_next = 1'b1;
            default:  par_next = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Par_Bit <= 1'b0;
        end else if (load) begin
            Par_Bit <= par_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_frame.sv
// ============================================================================
// uart_tx_frame : UART transmit framer/serialiser with runtime length, parity
//                 mode and stop-bit count; one line bit per CLK cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter int   LEN_W      = 4,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic [LEN_W-1:0]      DATA_LEN,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_MODE,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  Par_Bit,
    output logic                  Frame_Done
);

    tx_state_t             state, state_nxt;
    logic [LEN_W-1:0]      cnt, cnt_nxt;
    logic [LEN_W-1:0]      len_r, len_eff;
    logic [DATA_WIDTH-1:0] data_r, data_masked, data_shift;
    logic                  par_en_r, stop2_r;
    logic                  accept, tx_nxt, done_nxt;

    assign accept = (state == ST_IDLE) && Data_Valid;

    always_comb begin
        if (DATA_LEN < LEN_W'(MIN_LEN)) begin
            len_eff = LEN_W'(MIN_LEN);
        end else if (DATA_LEN > LEN_W'(DATA_WIDTH)) begin
            len_eff = LEN_W'(DATA_WIDTH);
        end else begin
            len_eff = DATA_LEN;
        end
    end

    // Bits above the effective length are cleared so parity ignores them
    always_comb begin
        data_masked = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data_masked[i] = P_DATA[i] & (LEN_W'(i) < len_eff);
        end
    end

    uart_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .CLK         (CLK),
        .RST         (RST),
        .masked_data (data_masked),
        .mode        (PAR_MODE),
        .load        (accept),
        .Par_Bit     (Par_Bit)
    );

    // cnt indexes data bits in DATA and counts stop bits in STOP
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = ST_START;
            end
            ST_START: begin
                state_nxt = ST_DATA;
                cnt_nxt   = '0;
            end
            ST_DATA: begin
                if (cnt == len_r - LEN_W'(1)) begin
                    state_nxt = par_en_r ? ST_PARITY : ST_STOP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + LEN_W'(1);
                end
            end
            ST_PARITY: begin
                state_nxt = ST_STOP;
                cnt_nxt   = '0;
            end
            ST_STOP: begin
                if (stop2_r && (cnt == '0)) begin
                    cnt_nxt = LEN_W'(1);
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign data_shift = data_r >> cnt_nxt;

    always_comb begin
        tx_nxt = IDLE_LEVEL;
        case (state_nxt)
            ST_START:  tx_nxt = ~IDLE_LEVEL;
            ST_DATA:   tx_nxt = data_shift[0];
            ST_PARITY: tx_nxt = Par_Bit;
            default:   tx_nxt = IDLE_LEVEL;
        endcase
        done_nxt = (state_nxt == ST_STOP) && (!stop2_r || (cnt_nxt == LEN_W'(1)));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            data_r     <= '0;
            len_r      <= '0;
            par_en_r   <= 1'b0;
            stop2_r    <= 1'b0;
            TX_OUT     <= IDLE_LEVEL;
            BUSY       <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            TX_OUT     <= tx_nxt;
            BUSY       <= (state_nxt != ST_IDLE);
            Frame_Done <= done_nxt;
            if (accept) begin
                data_r   <= data_masked;
                len_r    <= len_eff;
                par_en_r <= PAR_EN;
                stop2_r  <= STOP2;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ============================================================================
// tb_uart_tx_frame : self-checking bench for uart_tx_frame (8- and 9-bit builds)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_frame;
    import uart_pkg::*;

    logic       CLK, RST;
    logic [8:0] p_data;
    logic       Data_Valid, PAR_EN, STOP2;
    logic [3:0] DATA_LEN;
    logic [1:0] PAR_MODE;
    logic       tx8, busy8, par8, done8;
    logic       tx9, busy9, par9, done9;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_frame #(.DATA_WIDTH(8), .LEN_W(4), .IDLE_LEVEL(1'b1)) u8 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data[7:0]), .Data_Valid(Data_Valid),
        .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .STOP2(STOP2),
        .TX_OUT(tx8), .BUSY(busy8), .Par_Bit(par8), .Frame_Done(done8)
    );

    uart_tx_frame #(.DATA_WIDTH(9), .LEN_W(4), .IDLE_LEVEL(1'b1)) u9 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data), .Data_Valid(Data_Valid),
        .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE), .STOP2(STOP2),
        .TX_OUT(tx9), .BUSY(busy9), .Par_Bit(par9), .Frame_Done(done9)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
        logic par;
    } exp_t;

    exp_t q8[$];
    exp_t q9[$];

    // Directed vectors; line is MSB-first in time order, expectations for the 8-bit build
    typedef struct {
        logic [8:0]  data;
        logic [3:0]  len;
        logic        pe;
        logic [1:0]  mode;
        logic        s2;
        logic [15:0] line;
        int          nbits;
        logic        par;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Reference: frame built bit by bit from the framing rules
    function automatic void model(input logic [8:0] d, input int len, input bit pe,
                                  input logic [1:0] m, input bit s2, input int w,
                                  output logic [15:0] line, output int n, output bit par);
        int eff;
        bit x;
        eff = (len < MIN_LEN) ? MIN_LEN : ((len > w) ? w : len);
        x = 1'b0;
        for (int i = 0; i < eff; i++) x ^= d[i];
        case (m)
            PAR_EVEN: par = x;
            PAR_ODD:  par = !x;
            PAR_MARK: par = 1'b1;
            default:  par = 1'b0;
        endcase
        line = '0;
        n = 0;
        line = {line[14:0], 1'b0}; n++;
        for (int i = 0; i < eff; i++) begin
            line = {line[14:0], d[i]}; n++;
        end
        if (pe) begin
            line = {line[14:0], par}; n++;
        end
        line = {line[14:0], 1'b1}; n++;
        if (s2) begin
            line = {line[14:0], 1'b1}; n++;
        end
    endfunction

    task automatic push_frame(input int which, input logic [15:0] line, input int n, input bit par);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e = '{tx: line[n-1-k], busy: 1'b1, done: (k == n - 1), par: par};
            if (which == 8) q8.push_back(e); else q9.push_back(e);
        end
        e = '{tx: 1'b1, busy: 1'b0, done: 1'b0, par: par};
        if (which == 8) q8.push_back(e); else q9.push_back(e);
    endtask

    task automatic push_model(input int which, input logic [8:0] d, input int len, input bit pe,
                              input logic [1:0] m, input bit s2);
        logic [15:0] line;
        int n;
        bit par;
        model(d, len, pe, m, s2, which, line, n, par);
        push_frame(which, line, n, par);
    endtask

    // Compares one expected record per cycle at the falling edge
    task automatic run_stream(input int drop_at);
        exp_t e;
        int i;
        i = 0;
        while (q8.size() > 0 || q9.size() > 0) begin
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check($sformatf("u8 tx c%0d", i), tx8, e.tx);
                check($sformatf("u8 busy c%0d", i), busy8, e.busy);
                check($sformatf("u8 done c%0d", i), done8, e.done);
                check($sformatf("u8 par c%0d", i), par8, e.par);
            end
            if (q9.size() > 0) begin
                e = q9.pop_front();
                check($sformatf("u9 tx c%0d", i), tx9, e.tx);
                check($sformatf("u9 busy c%0d", i), busy9, e.busy);
                check($sformatf("u9 done c%0d", i), done9, e.done);
                check($sformatf("u9 par c%0d", i), par9, e.par);
            end
            if (i == drop_at) Data_Valid = 1'b0;
            i++;
            @(negedge CLK);
        end
    endtask

    task automatic drive(input logic [8:0] d, input logic [3:0] len, input logic pe,
                         input logic [1:0] m, input logic s2);
        p_data   = d;
        DATA_LEN = len;
        PAR_EN   = pe;
        PAR_MODE = m;
        STOP2    = s2;
    endtask

    // One frame; inputs are scrambled after acceptance to prove they are shadowed
    task automatic apply(input logic [8:0] d, input logic [3:0] len, input logic pe,
                         input logic [1:0] m, input logic s2);
        drive(d, len, pe, m, s2);
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        drive(9'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
        run_stream(-1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " u8 tx"}, tx8, 1'b1);
        check({tag, " u8 busy"}, busy8, 1'b0);
        check({tag, " u8 par"}, par8, 1'b0);
        check({tag, " u8 done"}, done8, 1'b0);
        check({tag, " u9 tx"}, tx9, 1'b1);
        check({tag, " u9 busy"}, busy9, 1'b0);
        check({tag, " u9 par"}, par9, 1'b0);
        check({tag, " u9 done"}, done9, 1'b0);
    endtask

    initial begin
        logic [8:0] rd;
        logic [3:0] rl;
        logic       rpe, rs2;
        logic [1:0] rm;

        tbl[0] = '{9'h0A5, 4'd8,  1'b1, PAR_EVEN,  1'b0, 16'b01010010101, 11, 1'b0};
        tbl[1] = '{9'h1F3, 4'd7,  1'b1, PAR_ODD,   1'b1, 16'b01100111011, 11, 1'b0};
        tbl[2] = '{9'h015, 4'd5,  1'b0, PAR_EVEN,  1'b0, 16'b0101011,     7,  1'b1};
        tbl[3] = '{9'h000, 4'd8,  1'b1, PAR_MARK,  1'b0, 16'b00000000011, 11, 1'b1};
        tbl[4] = '{9'h0FF, 4'd8,  1'b1, PAR_SPACE, 1'b0, 16'b01111111101, 11, 1'b0};
        tbl[5] = '{9'h0FF, 4'd2,  1'b1, PAR_EVEN,  1'b0, 16'b01111111,    8,  1'b1};
        tbl[6] = '{9'h1FF, 4'd15, 1'b1, PAR_EVEN,  1'b0, 16'b01111111101, 11, 1'b0};
        tbl[7] = '{9'h00F, 4'd6,  1'b1, PAR_ODD,   1'b1, 16'b0111100111,  10, 1'b1};

        RST = 1'b1;
        Data_Valid = 1'b0;
        drive(9'h0, 4'd8, 1'b0, PAR_EVEN, 1'b0);
        #1;
        check_reset_state("reset");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_reset_state("idle");

        for (int i = 0; i < 8; i++) begin
            push_frame(8, tbl[i].line, tbl[i].nbits, tbl[i].par);
            push_model(9, tbl[i].data, int'(tbl[i].len), tbl[i].pe, tbl[i].mode, tbl[i].s2);
            apply(tbl[i].data, tbl[i].len, tbl[i].pe, tbl[i].mode, tbl[i].s2);
        end

        for (int i = 0; i < 24; i++) begin
            rd  = 9'($urandom);
            rl  = 4'($urandom_range(0, 15));
            rpe = 1'($urandom);
            rm  = 2'($urandom);
            rs2 = 1'($urandom);
            push_model(8, rd, int'(rl), rpe, rm, rs2);
            push_model(9, rd, int'(rl), rpe, rm, rs2);
            apply(rd, rl, rpe, rm, rs2);
        end

        // Reset during data bit 3 of 0xA5 (odd parity, so Par_Bit is 1 beforehand)
        drive(9'h0A5, 4'd8, 1'b1, PAR_ODD, 1'b0);
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("pre-reset u8 tx bit3", tx8, 1'b0);
        check("pre-reset u8 par", par8, 1'b1);
        check("pre-reset u8 busy", busy8, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        check_reset_state("async reset");
        @(posedge CLK);
        #1;
        check_reset_state("held reset");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_reset_state("post reset");
        push_model(8, 9'h0A5, 8, 1'b1, PAR_EVEN, 1'b0);
        push_model(9, 9'h0A5, 8, 1'b1, PAR_EVEN, 1'b0);
        apply(9'h0A5, 4'd8, 1'b1, PAR_EVEN, 1'b0);

        // Back-to-back with Data_Valid held high; second config applied mid-frame
        push_model(8, 9'h03C, 6, 1'b1, PAR_EVEN, 1'b0);
        push_model(9, 9'h03C, 6, 1'b1, PAR_EVEN, 1'b0);
        push_model(8, 9'h1C5, 9, 1'b0, PAR_ODD, 1'b1);
        push_model(9, 9'h1C5, 9, 1'b0, PAR_ODD, 1'b1);
        drive(9'h03C, 4'd6, 1'b1, PAR_EVEN, 1'b0);
        Data_Valid = 1'b1;
        @(negedge CLK);
        drive(9'h1C5, 4'd9, 1'b0, PAR_ODD, 1'b1);
        run_stream(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
